// File: rtl/pkt_src_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC packet streams into one translator input.
// Optional stall watchdog with flush state: define PKT_SRC_ARBITER_WATCHDOG_EN.
module pkt_src_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 256,
  localparam int unsigned SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
`ifdef PKT_SRC_ARBITER_WATCHDOG_EN
  localparam int unsigned ERR_W     = 3
`else
  localparam int unsigned ERR_W     = 2
`endif
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic [NUM_SRC-1:0]            s_valid,
  input  logic [NUM_SRC-1:0]            s_sop,
  input  logic [NUM_SRC-1:0]            s_eop,
  input  logic [2*NUM_SRC-1:0]          s_residual,
  input  logic [NUM_SRC-1:0]            s_bad,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_data,
  output logic [NUM_SRC-1:0]            s_ready,
  input  logic                          ipause,
  output logic                          m_valid,
  output logic                          m_sop,
  output logic                          m_eop,
  output logic [1:0]                    m_residual,
  output logic                          m_bad,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [SRC_W-1:0]              m_src,
  output logic [15:0]                   opkt_cnt,
  output logic [ERR_W-1:0]              oerr
);

  if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT < 1 || DATA_WIDTH < 1) begin : g_param_check
    $error("pkt_src_arbiter: parameter out of range");
  end

`ifdef PKT_SRC_ARBITER_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, PKT, FLUSH} state_t;
  logic [WD_W-1:0] wd_cnt;
`else
  typedef enum logic [1:0] {IDLE, PKT} state_t;
`endif

  state_t                 state;
  logic [SRC_W-1:0]       grant;
  logic [SRC_W-1:0]       ptr;
  logic                   mid;

  logic                   sel_valid, sel_sop, sel_eop, sel_bad;
  logic [1:0]             sel_res;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [NUM_SRC-1:0]     req, gmask;
  logic                   found;
  logic [SRC_W-1:0]       winner;
  logic                   orphan_hit;
  logic                   acc;
  int                     idx;

  // Granted-source beat mux
  always_comb begin
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_bad   = 1'b0;
    sel_res   = 2'd0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == SRC_W'(i)) begin
        sel_valid = s_valid[i];
        sel_sop   = s_sop[i];
        sel_eop   = s_eop[i];
        sel_bad   = s_bad[i];
        sel_res   = s_residual[2*i +: 2];
        sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Circular search for the first sop requester at or after the pointer
  always_comb begin
    req    = s_valid & s_sop;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % int'(NUM_SRC);
      if (!found && req[SRC_W'(idx)]) begin
        found  = 1'b1;
        winner = SRC_W'(idx);
      end
    end
  end

  // Granted source gets ready; any other non-sop beat is an orphan and is drained
  always_comb begin
    gmask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      gmask[i] = (state != IDLE) && (grant == SRC_W'(i));
    end
    s_ready    = ipause ? '0 : (gmask | (s_valid & ~s_sop));
    orphan_hit = |(s_valid & s_ready & ~gmask);
    acc        = sel_valid & ~ipause;
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state      <= IDLE;
      grant      <= '0;
      ptr        <= '0;
      mid        <= 1'b0;
      m_valid    <= 1'b0;
      m_sop      <= 1'b0;
      m_eop      <= 1'b0;
      m_bad      <= 1'b0;
      m_residual <= 2'd0;
      m_data     <= '0;
      m_src      <= '0;
      opkt_cnt   <= 16'd0;
      oerr       <= '0;
`ifdef PKT_SRC_ARBITER_WATCHDOG_EN
      wd_cnt     <= '0;
`endif
    end else begin
      m_valid  <= 1'b0;
      m_sop    <= 1'b0;
      m_eop    <= 1'b0;
      m_bad    <= 1'b0;
      opkt_cnt <= opkt_cnt + 16'(m_valid & m_eop);
      if (orphan_hit) oerr[0] <= 1'b1;

      case (state)
        IDLE: begin
          if (!ipause && found) begin
            grant <= winner;
            ptr   <= (winner == SRC_W'(NUM_SRC - 1)) ? '0 : winner + SRC_W'(1);
            mid   <= 1'b0;
            state <= PKT;
`ifdef PKT_SRC_ARBITER_WATCHDOG_EN
            wd_cnt <= '0;
`endif
          end
        end
        PKT: begin
          if (acc) begin
            // A second sop inside a packet is forwarded as a bad continuation beat
            m_valid    <= 1'b1;
            m_sop      <= sel_sop & ~mid;
            m_eop      <= sel_eop;
            m_bad      <= sel_bad | (sel_sop & mid);
            m_residual <= sel_res;
            m_data     <= sel_data;
            m_src      <= grant;
            mid        <= 1'b1;
            if (sel_sop && mid) oerr[1] <= 1'b1;
            if (sel_eop) state <= IDLE;
`ifdef PKT_SRC_ARBITER_WATCHDOG_EN
            wd_cnt <= '0;
          end else if (!ipause) begin
            if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
              m_valid    <= 1'b1;
              m_eop      <= 1'b1;
              m_bad      <= 1'b1;
              m_residual <= 2'd0;
              m_data     <= '0;
              m_src      <= grant;
              oerr[2]    <= 1'b1;
              wd_cnt     <= '0;
              state      <= FLUSH;
            end else begin
              wd_cnt <= wd_cnt + WD_W'(1);
            end
`endif
          end
        end
`ifdef PKT_SRC_ARBITER_WATCHDOG_EN
        FLUSH: begin
          if (acc && sel_eop) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_src_arbiter.sv
// Directed self-checking bench for pkt_src_arbiter (watchdog section runs when
// PKT_SRC_ARBITER_WATCHDOG_EN is defined).
module tb_pkt_src_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 2;
`ifdef PKT_SRC_ARBITER_WATCHDOG_EN
  localparam int unsigned EW = 3;
`else
  localparam int unsigned EW = 2;
`endif

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [1:0]    res;
    logic          bad;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [SW-1:0] src;
    beat_t         b;
  } obeat_t;

  logic            iclk = 1'b0;
  logic            irst = 1'b1;
  logic [N-1:0]    s_valid = '0, s_sop = '0, s_eop = '0, s_bad = '0;
  logic [2*N-1:0]  s_residual = '0;
  logic [N*DW-1:0] s_data = '0;
  logic [N-1:0]    s_ready;
  logic            ipause = 1'b0;
  logic            m_valid, m_sop, m_eop, m_bad;
  logic [1:0]      m_residual;
  logic [DW-1:0]   m_data;
  logic [SW-1:0]   m_src;
  logic [15:0]     opkt_cnt;
  logic [EW-1:0]   oerr;

  beat_t   q [N][$];
  obeat_t  log_q [$];
  int      lcyc [$];
  logic [N-1:0] take = '0;
  int      cyc = 0;
  int      total = 0;
  int      bad = 0;
  int      ord [5] = '{0, 1, 2, 3, 0};
  int      pk  [5] = '{0, 0, 0, 0, 1};

  pkt_src_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .iclk(iclk), .irst(irst),
    .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_residual(s_residual),
    .s_bad(s_bad), .s_data(s_data), .s_ready(s_ready), .ipause(ipause),
    .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_residual(m_residual),
    .m_bad(m_bad), .m_data(m_data), .m_src(m_src), .opkt_cnt(opkt_cnt), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  // Source driver: presents queue heads, pops beats that transferred
  initial begin
    forever begin
      @(negedge iclk);
      for (int i = 0; i < N; i++)
        if (take[i] && q[i].size() > 0) void'(q[i].pop_front());
      for (int i = 0; i < N; i++) begin
        if (q[i].size() > 0) begin
          s_valid[i]           = 1'b1;
          s_sop[i]             = q[i][0].sop;
          s_eop[i]             = q[i][0].eop;
          s_residual[2*i +: 2] = q[i][0].res;
          s_bad[i]             = q[i][0].bad;
          s_data[i*DW +: DW]   = q[i][0].data;
        end else begin
          s_valid[i]           = 1'b0;
          s_sop[i]             = 1'b0;
          s_eop[i]             = 1'b0;
          s_residual[2*i +: 2] = 2'd0;
          s_bad[i]             = 1'b0;
          s_data[i*DW +: DW]   = '0;
        end
      end
      #1 take = s_valid & s_ready;
    end
  end

  // Output monitor: logs every m_valid beat with its cycle number
  initial begin
    obeat_t ob;
    forever begin
      @(posedge iclk);
      cyc = cyc + 1;
      #1;
      if (m_valid === 1'b1) begin
        ob = {m_src, m_sop, m_eop, m_residual, m_bad, m_data};
        log_q.push_back(ob);
        lcyc.push_back(cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  function automatic beat_t mb(input logic sop, input logic eop, input logic [1:0] res,
                               input logic bd, input logic [DW-1:0] data);
    beat_t b;
    b = {sop, eop, res, bd, data};
    return b;
  endfunction

  function automatic obeat_t mo(input int src, input beat_t b);
    obeat_t o;
    o = {SW'(src), b};
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      @(negedge iclk);
      k++;
    end
    check(tag, 64'(log_q.size() >= n), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iclk);
  endtask

  task automatic clear_log();
    log_q.delete();
    lcyc.delete();
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_outputs", 64'({m_valid, m_sop, m_eop, m_bad, m_residual, m_src, m_data}), 64'd0);
    check("rst_pkt_cnt", 64'(opkt_cnt), 64'd0);
    check("rst_err", 64'(oerr), 64'd0);
    irst = 1'b0;
    idle(2);
    check("idle_ready", 64'(s_ready), 64'd0);

    // Four simultaneous 3-beat packets plus a second packet on src0
    for (int s = 0; s < N; s++)
      for (int b = 0; b < 3; b++)
        q[s].push_back(mb(b == 0, b == 2, 2'd0, 1'b0, DW'((s << 24) | b)));
    for (int b = 0; b < 3; b++)
      q[0].push_back(mb(b == 0, b == 2, 2'd0, 1'b0, DW'(32'h100 | b)));
    wait_log(13, 100, "t1_wait13");
    check("t1_pkt_cnt4", 64'(opkt_cnt), 64'd4);
    wait_log(15, 20, "t1_wait15");
    for (int k = 0; k < 15; k++)
      check("t1_beat", 64'(log_q[k]),
            64'(mo(ord[k/3], mb(k%3 == 0, k%3 == 2, 2'd0, 1'b0,
                                 DW'((ord[k/3] << 24) | (pk[k/3] << 8) | (k%3))))));
    for (int k = 0; k < 14; k++)
      check("t1_gap", 64'(lcyc[k+1] - lcyc[k]), (k%3 == 2) ? 64'd2 : 64'd1);
    idle(4);
    clear_log();

    // Single-beat packet on src2
    q[2].push_back(mb(1'b1, 1'b1, 2'd2, 1'b0, 32'hA5A5A5A5));
    wait_log(1, 20, "t2_wait");
    check("t2_beat", 64'(log_q[0]), 64'(mo(2, mb(1'b1, 1'b1, 2'd2, 1'b0, 32'hA5A5A5A5))));
    idle(3);
    check("t2_count", 64'(log_q.size()), 64'd1);
    check("t2_mvalid_low", 64'(m_valid), 64'd0);
    clear_log();

    // Five-cycle pause in the middle of a 6-beat src1 packet
    for (int b = 0; b < 6; b++)
      q[1].push_back(mb(b == 0, b == 5, 2'd0, 1'b0, DW'(32'h11000000 | b)));
    wait_log(2, 20, "t3_wait2");
    ipause = 1'b1;
    #2 check("t3_ready_paused", 64'(s_ready), 64'd0);
    for (int j = 1; j < 5; j++) begin
      @(negedge iclk);
      #2;
      check("t3_ready_paused", 64'(s_ready), 64'd0);
      check("t3_mvalid_paused", 64'(m_valid), 64'd0);
    end
    @(negedge iclk);
    ipause = 1'b0;
    wait_log(6, 30, "t3_wait6");
    for (int b = 0; b < 6; b++)
      check("t3_beat", 64'(log_q[b]),
            64'(mo(1, mb(b == 0, b == 5, 2'd0, 1'b0, DW'(32'h11000000 | b)))));
    idle(3);
    check("t3_count", 64'(log_q.size()), 64'd6);
    clear_log();

    // Orphan beat on src1 while src0 holds the grant
    for (int b = 0; b < 3; b++)
      q[0].push_back(mb(b == 0, b == 2, 2'd0, 1'b0, DW'(32'h200 | b)));
    wait_log(1, 20, "t4_wait1");
    q[1].push_back(mb(1'b0, 1'b0, 2'd0, 1'b0, 32'hDEADBEEF));
    wait_log(3, 20, "t4_wait3");
    idle(3);
    check("t4_orphan_drained", 64'(q[1].size()), 64'd0);
    check("t4_err", 64'(oerr), 64'd1);
    check("t4_count", 64'(log_q.size()), 64'd3);
    for (int b = 0; b < 3; b++)
      check("t4_beat", 64'(log_q[b]),
            64'(mo(0, mb(b == 0, b == 2, 2'd0, 1'b0, DW'(32'h200 | b)))));
    clear_log();

    // Mid-packet sop on src3, then src0 proves the grant was released
    q[3].push_back(mb(1'b1, 1'b0, 2'd0, 1'b0, 32'h33000000));
    q[3].push_back(mb(1'b1, 1'b0, 2'd0, 1'b0, 32'h33000001));
    q[3].push_back(mb(1'b0, 1'b0, 2'd0, 1'b0, 32'h33000002));
    q[3].push_back(mb(1'b0, 1'b1, 2'd3, 1'b0, 32'h33000003));
    wait_log(4, 20, "t5_wait4");
    check("t5_b0", 64'(log_q[0]), 64'(mo(3, mb(1'b1, 1'b0, 2'd0, 1'b0, 32'h33000000))));
    check("t5_b1_bad", 64'(log_q[1]), 64'(mo(3, mb(1'b0, 1'b0, 2'd0, 1'b1, 32'h33000001))));
    check("t5_b2", 64'(log_q[2]), 64'(mo(3, mb(1'b0, 1'b0, 2'd0, 1'b0, 32'h33000002))));
    check("t5_b3", 64'(log_q[3]), 64'(mo(3, mb(1'b0, 1'b1, 2'd3, 1'b0, 32'h33000003))));
    check("t5_err", 64'(oerr), 64'd3);
    q[0].push_back(mb(1'b1, 1'b1, 2'd1, 1'b0, 32'h0000BEEF));
    wait_log(5, 20, "t5_wait5");
    check("t5_next_grant", 64'(log_q[4]), 64'(mo(0, mb(1'b1, 1'b1, 2'd1, 1'b0, 32'h0000BEEF))));
    idle(2);
    check("t5_pkt_cnt", 64'(opkt_cnt), 64'd10);
    clear_log();

`ifdef PKT_SRC_ARBITER_WATCHDOG_EN
    // src0 stalls after its sop; watchdog closes the packet and flushes the rest
    q[0].push_back(mb(1'b1, 1'b0, 2'd0, 1'b0, 32'hC0C00000));
    wait_log(1, 20, "t6_wait1");
    q[1].push_back(mb(1'b1, 1'b0, 2'd0, 1'b0, 32'h1C1C0000));
    q[1].push_back(mb(1'b0, 1'b1, 2'd0, 1'b0, 32'h1C1C0001));
    wait_log(2, 30, "t6_wait_synth");
    check("t6_synth_beat", 64'(log_q[1]), 64'(mo(0, mb(1'b0, 1'b1, 2'd0, 1'b1, 32'h0))));
    check("t6_synth_delay", 64'(lcyc[1] - lcyc[0]), 64'd8);
    check("t6_err_timeout", 64'(oerr[2]), 64'd1);
    q[0].push_back(mb(1'b0, 1'b0, 2'd0, 1'b0, 32'hC0C00001));
    q[0].push_back(mb(1'b0, 1'b1, 2'd0, 1'b0, 32'hC0C00002));
    wait_log(4, 40, "t6_wait_src1");
    check("t6_src1_b0", 64'(log_q[2]), 64'(mo(1, mb(1'b1, 1'b0, 2'd0, 1'b0, 32'h1C1C0000))));
    check("t6_src1_b1", 64'(log_q[3]), 64'(mo(1, mb(1'b0, 1'b1, 2'd0, 1'b0, 32'h1C1C0001))));
    check("t6_flushed", 64'(q[0].size()), 64'd0);
    idle(3);
    check("t6_count", 64'(log_q.size()), 64'd4);
    check("t6_pkt_cnt", 64'(opkt_cnt), 64'd12);
    check("t6_err", 64'(oerr), 64'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
